// File: rtl/cache_ctrl_pkg.sv
// Shared definitions for the direct-mapped write-through cache controller:
// FSM state encoding, default geometry and tag-width derivation.
package cache_ctrl_pkg;

  localparam int ADDR_W        = 32;
  localparam int LINE_BITS_DEF = 4;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FILL  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] WDONE = 2'd3;

  function automatic int tag_width(input int line_bits);
    return ADDR_W - line_bits;
  endfunction

endpackage

// File: rtl/cache_ctrl_if.sv
// CPU-side and memory-side request bundle of the cache controller.
// slave = the cache controller, master = the CPU/memory environment around it.
interface cache_ctrl_if;

  logic        cpu_cs;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_din;
  logic [31:0] cpu_dout;
  logic        cpu_stall;

  logic        mem_cs;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;
  logic        mem_ack;

  modport slave (
    input  cpu_cs, cpu_we, cpu_addr, cpu_din,
    output cpu_dout, cpu_stall,
    output mem_cs, mem_we, mem_addr, mem_din,
    input  mem_dout, mem_ack
  );

  modport master (
    output cpu_cs, cpu_we, cpu_addr, cpu_din,
    input  cpu_dout, cpu_stall,
    input  mem_cs, mem_we, mem_addr, mem_din,
    output mem_dout, mem_ack
  );

endinterface

// File: rtl/cache_array.sv
// Tag/valid/data storage: one write port, combinational read by index.
// Only the valid bits are reset; tag and data contents are don't-care until valid.
module cache_array #(
  parameter int LINE_BITS = 4,
  parameter int TAG_W     = 28
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [LINE_BITS-1:0] rd_idx,
  output logic                 rd_valid,
  output logic [TAG_W-1:0]     rd_tag,
  output logic [31:0]          rd_data,
  input  logic                 wr_en,
  input  logic [LINE_BITS-1:0] wr_idx,
  input  logic [TAG_W-1:0]     wr_tag,
  input  logic [31:0]          wr_data
);

  localparam int NLINES = 1 << LINE_BITS;

  logic [NLINES-1:0] valid;
  logic [TAG_W-1:0]  tags  [NLINES];
  logic [31:0]       words [NLINES];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tags[wr_idx]  <= wr_tag;
      words[wr_idx] <= wr_data;
    end
  end

  assign rd_valid = valid[rd_idx];
  assign rd_tag   = tags[rd_idx];
  assign rd_data  = words[rd_idx];

endmodule

// File: rtl/cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate cache: read hits complete in the
// same cycle; misses and writes stall the CPU until memory acks (plus one cycle).
module cache_ctrl
  import cache_ctrl_pkg::*;
#(
  parameter int LINE_BITS = LINE_BITS_DEF,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  cache_ctrl_if.slave          bus,
  output logic [CNT_WIDTH-1:0] hit_cnt,
  output logic [CNT_WIDTH-1:0] miss_cnt
);

  localparam int TAG_W = tag_width(LINE_BITS);

  logic [1:0]           state;
  logic [31:0]          req_addr;
  logic [31:0]          req_data;
  logic                 fill_done;

  logic [LINE_BITS-1:0] rd_idx;
  logic [TAG_W-1:0]     look_tag;
  logic                 line_valid;
  logic [TAG_W-1:0]     line_tag;
  logic [31:0]          line_data;
  logic                 hit;
  logic                 rd_hit;
  logic                 arr_we;
  logic [31:0]          arr_wdata;

  // Outside IDLE the lookup follows the held request so WRITE can test for a hit at ack.
  always_comb begin
    if (state == IDLE) begin
      rd_idx   = bus.cpu_addr[LINE_BITS-1:0];
      look_tag = bus.cpu_addr[31:LINE_BITS];
    end else begin
      rd_idx   = req_addr[LINE_BITS-1:0];
      look_tag = req_addr[31:LINE_BITS];
    end
  end

  assign hit    = line_valid && (line_tag == look_tag);
  assign rd_hit = (state == IDLE) && bus.cpu_cs && !bus.cpu_we && hit;

  assign arr_we    = bus.mem_ack && ((state == FILL) || ((state == WRITE) && hit));
  assign arr_wdata = (state == FILL) ? bus.mem_dout : req_data;

  cache_array #(
    .LINE_BITS (LINE_BITS),
    .TAG_W     (TAG_W)
  ) u_array (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (rd_idx),
    .rd_valid (line_valid),
    .rd_tag   (line_tag),
    .rd_data  (line_data),
    .wr_en    (arr_we),
    .wr_idx   (req_addr[LINE_BITS-1:0]),
    .wr_tag   (req_addr[31:LINE_BITS]),
    .wr_data  (arr_wdata)
  );

  always_comb begin
    bus.cpu_stall = 1'b0;
    case (state)
      IDLE:         bus.cpu_stall = bus.cpu_cs && (bus.cpu_we || !hit);
      FILL, WRITE:  bus.cpu_stall = 1'b1;
      default:      bus.cpu_stall = 1'b0;
    endcase
  end

  assign bus.cpu_dout = rd_hit ? line_data : 32'h0;
  assign bus.mem_cs   = (state == FILL) || (state == WRITE);
  assign bus.mem_we   = (state == WRITE);
  assign bus.mem_addr = req_addr;
  assign bus.mem_din  = req_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      req_addr  <= '0;
      req_data  <= '0;
      hit_cnt   <= '0;
      miss_cnt  <= '0;
      fill_done <= 1'b0;
    end else begin
      fill_done <= (state == FILL) && bus.mem_ack;
      case (state)
        IDLE: begin
          if (bus.cpu_cs) begin
            if (bus.cpu_we) begin
              req_addr <= bus.cpu_addr;
              req_data <= bus.cpu_din;
              state    <= WRITE;
            end else if (!hit) begin
              req_addr <= bus.cpu_addr;
              if (miss_cnt != '1) miss_cnt <= miss_cnt + 1'b1;
              state    <= FILL;
            end else if (!fill_done) begin
              // The hit right after a fill completes the access that already missed.
              if (hit_cnt != '1) hit_cnt <= hit_cnt + 1'b1;
            end
          end
        end
        FILL:    if (bus.mem_ack) state <= IDLE;
        WRITE:   if (bus.mem_ack) state <= WDONE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed bench for cache_ctrl with a transaction-level cache/memory model and a
// per-cycle compare process; counters use a narrow width so saturation is reachable.
module tb_cache_ctrl;

  localparam int CW      = 3;
  localparam int MEM_LAT = 7;

  logic          clk;
  logic          rst;
  logic [CW-1:0] hit_cnt;
  logic [CW-1:0] miss_cnt;

  cache_ctrl_if bus();

  cache_ctrl #(
    .LINE_BITS (4),
    .CNT_WIDTH (CW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Memory: word i holds i; ack pulses MEM_LAT cycles after a request is first seen,
  // and a started access always completes even if the requester goes away.
  logic [31:0] mem_arr [256];
  bit          mbusy;
  int          mcnt;

  assign bus.mem_dout = mem_arr[bus.mem_addr[7:0]];

  initial begin
    for (int i = 0; i < 256; i++) mem_arr[i] = i;
    mbusy       = 1'b0;
    mcnt        = 0;
    bus.mem_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.mem_ack) begin
        bus.mem_ack = 1'b0;
      end else if (mbusy) begin
        mcnt++;
        if (mcnt == MEM_LAT) begin
          bus.mem_ack = 1'b1;
          mbusy       = 1'b0;
          if (bus.mem_we) mem_arr[bus.mem_addr[7:0]] = bus.mem_din;
        end
      end else if (bus.mem_cs) begin
        mbusy = 1'b1;
        mcnt  = 0;
      end
    end
  end

  // Reference cache contents and expected per-cycle outputs.
  logic          m_valid [16];
  logic [27:0]   m_tag   [16];
  logic [31:0]   m_data  [16];
  logic [CW-1:0] m_hit, m_miss;

  bit          exp_on;
  logic        e_stall, e_mcs, e_mwe;
  logic [31:0] e_dout, e_maddr, e_mdin;

  function automatic logic [CW-1:0] sat(input logic [CW-1:0] v);
    return (v == {CW{1'b1}}) ? v : v + 1'b1;
  endfunction

  task automatic set_idle();
    e_stall = 1'b0; e_dout = 32'h0; e_mcs = 1'b0; e_mwe = 1'b0;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0; m_tag[i] = '0; m_data[i] = '0;
    end
    m_hit  = '0;
    m_miss = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (exp_on) begin
        check("cpu_stall", 32'(bus.cpu_stall), 32'(e_stall));
        check("cpu_dout",  bus.cpu_dout, e_dout);
        check("mem_cs",    32'(bus.mem_cs), 32'(e_mcs));
        check("mem_we",    32'(bus.mem_we), 32'(e_mwe));
        if (e_mcs) check("mem_addr", bus.mem_addr, e_maddr);
        if (e_mwe) check("mem_din",  bus.mem_din,  e_mdin);
        check("hit_cnt",  32'(hit_cnt),  32'(m_hit));
        check("miss_cnt", 32'(miss_cnt), 32'(m_miss));
      end
    end
  end

  // Read access; with abort set, the CPU drops cs and moves the address mid-fill.
  task automatic do_read(input logic [31:0] a, input bit abort,
                         output int stalls, output logic [31:0] got);
    logic [3:0]  idx;
    logic [27:0] tg;
    bit          hit;
    idx    = a[3:0];
    tg     = a[31:4];
    hit    = m_valid[idx] && (m_tag[idx] == tg);
    stalls = 0;
    got    = 32'h0;
    bus.cpu_cs = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = a;
    if (hit) begin
      e_stall = 1'b0; e_dout = m_data[idx]; e_mcs = 1'b0; e_mwe = 1'b0;
      @(negedge clk);
      got = bus.cpu_dout;
      if (bus.cpu_stall) stalls++;
      tick();
      m_hit = sat(m_hit);
    end else begin
      e_stall = 1'b1; e_dout = 32'h0; e_mcs = 1'b0; e_mwe = 1'b0;
      @(negedge clk);
      if (bus.cpu_stall) stalls++;
      tick();
      m_miss = sat(m_miss);
      for (int k = 1; k <= MEM_LAT + 1; k++) begin
        if (abort && k == 3) begin
          bus.cpu_cs = 1'b0; bus.cpu_addr = a ^ 32'h100;
        end
        e_stall = 1'b1; e_dout = 32'h0; e_mcs = 1'b1; e_mwe = 1'b0; e_maddr = a;
        @(negedge clk);
        if (bus.cpu_stall) stalls++;
        tick();
      end
      m_valid[idx] = 1'b1; m_tag[idx] = tg; m_data[idx] = mem_arr[a[7:0]];
      e_stall = 1'b0; e_mcs = 1'b0; e_mwe = 1'b0;
      e_dout  = abort ? 32'h0 : m_data[idx];
      @(negedge clk);
      got = bus.cpu_dout;
      if (bus.cpu_stall) stalls++;
      tick();
    end
    bus.cpu_cs = 1'b0;
    set_idle();
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                          output int stalls, output bit done_low);
    logic [3:0] idx;
    bit         hit;
    idx    = a[3:0];
    hit    = m_valid[idx] && (m_tag[idx] == a[31:4]);
    stalls = 0;
    bus.cpu_cs = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = a; bus.cpu_din = d;
    e_stall = 1'b1; e_dout = 32'h0; e_mcs = 1'b0; e_mwe = 1'b0;
    @(negedge clk);
    if (bus.cpu_stall) stalls++;
    tick();
    for (int k = 1; k <= MEM_LAT + 1; k++) begin
      e_stall = 1'b1; e_mcs = 1'b1; e_mwe = 1'b1; e_maddr = a; e_mdin = d;
      @(negedge clk);
      if (bus.cpu_stall) stalls++;
      tick();
    end
    if (hit) m_data[idx] = d;
    set_idle();
    @(negedge clk);
    done_low = !bus.cpu_stall;
    tick();
    bus.cpu_cs = 1'b0; bus.cpu_we = 1'b0;
  endtask

  int          st;
  bit          wd;
  logic [31:0] rd;

  initial begin
    exp_on = 1'b0;
    rst    = 1'b0;
    bus.cpu_cs = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_din = '0;
    clear_model();
    set_idle();
    repeat (3) @(posedge clk);
    #1;
    check("reset_mem_cs",   32'(bus.mem_cs),    0);
    check("reset_stall",    32'(bus.cpu_stall), 0);
    check("reset_dout",     bus.cpu_dout,       0);
    check("reset_hit_cnt",  32'(hit_cnt),       0);
    check("reset_miss_cnt", 32'(miss_cnt),      0);
    rst = 1'b1;
    tick();
    exp_on = 1'b1;

    do_read(32'h5, 1'b0, st, rd);
    check("cold_stall_cycles", st, 9);
    check("cold_data", rd, 32'h5);
    check("cold_miss_cnt", 32'(miss_cnt), 1);
    check("cold_hit_cnt",  32'(hit_cnt),  0);

    do_read(32'h5, 1'b0, st, rd);
    check("hit_stall_cycles", st, 0);
    check("hit_data", rd, 32'h5);
    check("hit_cnt_1", 32'(hit_cnt), 1);

    do_read(32'h15, 1'b0, st, rd);
    check("conflict_data", rd, 32'h15);
    check("conflict_stall_cycles", st, 9);
    do_read(32'h5, 1'b0, st, rd);
    check("evicted_stall_cycles", st, 9);
    check("evicted_miss_cnt", 32'(miss_cnt), 3);

    do_read(32'h15, 1'b0, st, rd);
    do_write(32'h15, 32'hDEAD, st, wd);
    check("write_stall_cycles", st, 9);
    check("write_done_low", 32'(wd), 1);
    check("write_mem_word", mem_arr[8'h15], 32'hDEAD);
    do_read(32'h15, 1'b0, st, rd);
    check("write_hit_stall", st, 0);
    check("write_hit_data", rd, 32'hDEAD);

    do_write(32'h7, 32'h1234, st, wd);
    check("nwa_mem_word", mem_arr[8'h7], 32'h1234);
    do_read(32'h7, 1'b0, st, rd);
    check("nwa_read_stall", st, 9);
    check("nwa_read_data", rd, 32'h1234);
    check("nwa_miss_cnt", 32'(miss_cnt), 5);

    do_read(32'h2A, 1'b1, st, rd);
    check("abort_stall_cycles", st, 9);
    check("abort_dout", rd, 32'h0);
    do_read(32'h2A, 1'b0, st, rd);
    check("abort_line_filled", rd, 32'h2A);
    check("abort_hit_stall", st, 0);

    for (int i = 0; i < 6; i++) do_read(32'h2A, 1'b0, st, rd);
    check("hit_cnt_saturated", 32'(hit_cnt), 7);
    do_read(32'h3B, 1'b0, st, rd);
    do_read(32'h4C, 1'b0, st, rd);
    check("miss_cnt_saturated", 32'(miss_cnt), 7);

    // Reset in the middle of a fill; the memory still delivers its ack later.
    exp_on = 1'b0;
    bus.cpu_cs = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h9;
    tick(); tick(); tick();
    check("pre_reset_in_fill", 32'(bus.mem_cs), 1);
    rst = 1'b0;
    bus.cpu_cs = 1'b0;
    #1;
    check("midfill_rst_mem_cs",   32'(bus.mem_cs),    0);
    check("midfill_rst_mem_we",   32'(bus.mem_we),    0);
    check("midfill_rst_dout",     bus.cpu_dout,       0);
    check("midfill_rst_hit_cnt",  32'(hit_cnt),       0);
    check("midfill_rst_miss_cnt", 32'(miss_cnt),      0);
    tick();
    rst = 1'b1;
    clear_model();
    set_idle();
    exp_on = 1'b1;
    repeat (12) tick();
    do_read(32'h5, 1'b0, st, rd);
    check("post_reset_stall_cycles", st, 9);
    check("post_reset_data", rd, 32'h5);
    check("post_reset_miss_cnt", 32'(miss_cnt), 1);
    check("post_reset_hit_cnt",  32'(hit_cnt),  0);

    repeat (2) tick();
    exp_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/cache_ctrl.md
CACHE_CTRL -- requirements
Module: cache_ctrl

Interface
REQ-001 The block SHALL have parameter LINE_BITS, default 4, meaning log2 of the line count (16 one-word lines, direct-mapped).
REQ-002 The block SHALL have parameter CNT_WIDTH, default 16, meaning the width of the hit and miss counters.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset, with ports: clk  input  1  rising-edge clock; rst  input  1  asynchronous active-low reset.
REQ-004 The block SHALL have the CPU-side ports:
- cpu_cs  input  1  request valid
- cpu_we  input  1  1=write, 0=read
- cpu_addr  input  32  word address
- cpu_din  input  32  write data
- cpu_dout  output  32  read data
- cpu_stall  output  1  request not yet complete
REQ-005 The block SHALL have the memory-side ports:
- mem_cs  output  1  memory request
- mem_we  output  1  memory write
- mem_addr  output  32  word address
- mem_din  output  32  write data to memory
- mem_dout  input  32  read data from memory
- mem_ack  input  1  one-cycle completion pulse
REQ-006 The block SHALL have the counter ports hit_cnt  output  CNT_WIDTH  read-hit count and miss_cnt  output  CNT_WIDTH  read-miss count.

Function
REQ-007 Address split SHALL be: index = cpu_addr[LINE_BITS-1:0]; tag = cpu_addr[31:LINE_BITS]; hit = valid[index] and tag match.
REQ-008 The FSM SHALL have states IDLE, FILL, WRITE and WDONE.
REQ-009 In IDLE, a read hit SHALL complete in the same cycle: cpu_dout = line data, cpu_stall = 0, hit_cnt increments at the edge.
REQ-010 In IDLE, a read miss SHALL assert cpu_stall combinationally, latch cpu_addr into req_addr, increment miss_cnt and go to FILL.
REQ-011 In IDLE, any write SHALL assert cpu_stall, latch cpu_addr/cpu_din into req_addr/req_data and go to WRITE; write policy is write-through, no-write-allocate.
REQ-012 In FILL and WRITE, mem_cs SHALL be 1 and mem_addr = req_addr held stable; mem_we = 1 only in WRITE, where mem_din = req_data.
REQ-013 mem_cs and mem_we SHALL be decoded combinationally from state, so they fall in the cycle after mem_ack is sampled.
REQ-014 In FILL, on mem_ack, the block SHALL write mem_dout, the tag and valid=1 into line req_addr[index] and return to IDLE; the held read then hits, without incrementing hit_cnt for that access.
REQ-015 In WRITE, on mem_ack, the block SHALL update line data only if req_addr currently hits, then go to WDONE.
REQ-016 In WDONE, cpu_stall SHALL be 0 for exactly one cycle, then the FSM returns to IDLE.
REQ-017 cpu_stall SHALL be 1 in FILL and WRITE regardless of cpu_cs; in IDLE it SHALL be cpu_cs & (cpu_we | ~hit).
REQ-018 cpu_dout SHALL be 0 whenever no read hit is presented in IDLE.
REQ-019 A cpu_cs drop or cpu_addr change during FILL or WRITE SHALL NOT abort the memory transaction; the new request is evaluated in IDLE.
REQ-020 Counters SHALL saturate at all-ones.
REQ-021 Miss latency SHALL be 1 + (memory cycles to ack) + 1 cycles from request to cpu_stall low.

Reset
REQ-022 Asserting rst low SHALL immediately force state=IDLE, all valid bits=0, req_addr=0, req_data=0, hit_cnt=0 and miss_cnt=0.
REQ-023 Asserting rst low SHALL consequently force mem_cs=0, mem_we=0 and cpu_dout=0.
REQ-024 Reset mid-FILL or mid-WRITE SHALL abandon the transaction; a late mem_ack after reset SHALL be ignored in IDLE.
REQ-025 Tag and data arrays need no reset.

Structure
REQ-026 A shared package SHALL hold the state encoding, LINE_BITS default and the tag-width derivation (32-LINE_BITS).
REQ-027 The tag/valid/data storage SHALL be one sub-module, cache_array (one write port, combinational read by index), instantiated in cache_ctrl.

Verification
REQ-028 Bench memory model: word i = i, ack 7 cycles after request.
REQ-029 Cold read of addr 0x5 SHALL give stall for 9 cycles, then cpu_dout=0x5, miss_cnt=1, hit_cnt=0.
REQ-030 A repeat read of 0x5 SHALL return 0x5 with stall=0 in the same cycle and hit_cnt=1.
REQ-031 A read of 0x15 after 0x5 (same index, different tag) SHALL miss, return 0x15 and make a later read of 0x5 miss again (miss_cnt=3).
REQ-032 A write of 0xDEAD to cached 0x15 SHALL hold stall through WRITE plus ack, give one WDONE stall-low cycle, memory[0x15]=0xDEAD, and a next read hit returning 0xDEAD.
REQ-033 A write to uncached 0x7 SHALL update memory only, and a subsequent read of 0x7 SHALL miss.
REQ-034 Reset pulsed during FILL SHALL give mem_cs=0 immediately, all lines invalid, and the late ack ignored.
